// File: rtl/vx_fpu_sqrt_sched.sv
// vx_fpu_sqrt_sched: round-robin front end that shares one fixed-latency,
// stall-able FP square-root pipe among NUM_REQS requesters. The requester
// index rides in the upper tag bits through the pipe. A one-entry buffer
// routes each result back to its requester. A credit counter caps the number
// of issued-but-unreturned ops.
module vx_fpu_sqrt_sched #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_LANES     = 1,
    parameter int TAGW          = 8,
    parameter int LATENCY_FSQRT = 4,
    parameter int MAX_INFLIGHT  = LATENCY_FSQRT + 2,
    parameter int INST_FRM_BITS = 3,
    parameter int FP_FLAGS_BITS = 5,
    localparam int IDW  = $clog2(NUM_REQS),
    localparam int CNTW = $clog2(MAX_INFLIGHT + 1),
    localparam int DW   = NUM_LANES * 32,
    localparam int FW   = NUM_LANES * FP_FLAGS_BITS
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQS-1:0]               req_valid,
    output logic [NUM_REQS-1:0]               req_ready,
    input  logic [NUM_REQS*TAGW-1:0]          req_tag,
    input  logic [NUM_REQS*INST_FRM_BITS-1:0] req_frm,
    input  logic [NUM_REQS*DW-1:0]            req_data,
    output logic                              sqrt_valid_in,
    input  logic                              sqrt_ready_in,
    output logic [IDW+TAGW-1:0]               sqrt_tag_in,
    output logic [INST_FRM_BITS-1:0]          sqrt_frm,
    output logic [DW-1:0]                     sqrt_dataa,
    input  logic                              sqrt_valid_out,
    output logic                              sqrt_ready_out,
    input  logic [IDW+TAGW-1:0]               sqrt_tag_out,
    input  logic [DW-1:0]                     sqrt_result,
    input  logic                              sqrt_has_fflags,
    input  logic [FW-1:0]                     sqrt_fflags,
    output logic                              sqrt_reset,
    output logic [NUM_REQS-1:0]               rsp_valid,
    input  logic [NUM_REQS-1:0]               rsp_ready,
    output logic [TAGW-1:0]                   rsp_tag,
    output logic [DW-1:0]                     rsp_result,
    output logic                              rsp_has_fflags,
    output logic [FW-1:0]                     rsp_fflags,
    output logic                              busy
);

    logic [IDW-1:0]  rr_q, rr_d, grant, cand;
    logic            found;
    logic [CNTW-1:0] inflight_q, inflight_d;
    logic            credit_ok, can_issue, issue_fire, rsp_fire, cap;

    logic            buf_valid_q, buf_valid_d;
    logic [IDW-1:0]  buf_idx_q;
    logic [TAGW-1:0] buf_tag_q;
    logic [DW-1:0]   buf_res_q;
    logic            buf_hf_q;
    logic [FW-1:0]   buf_ff_q;

    // Round-robin search starting at rr_q; first valid requester wins.
    always_comb begin
        grant = rr_q;
        found = 1'b0;
        cand  = rr_q;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = IDW'((int'(rr_q) + k) % NUM_REQS);
            if (!found && req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign credit_ok     = inflight_q < CNTW'(MAX_INFLIGHT);
    assign can_issue     = sqrt_ready_in && credit_ok;
    assign sqrt_valid_in = found && credit_ok;
    assign issue_fire    = sqrt_valid_in && sqrt_ready_in;

    // Only the granted requester ever sees ready; nothing is granted without a request.
    always_comb begin
        req_ready = '0;
        req_ready[grant] = can_issue && found;
    end

    assign sqrt_tag_in = {grant, req_tag[int'(grant)*TAGW +: TAGW]};
    assign sqrt_frm    = req_frm[int'(grant)*INST_FRM_BITS +: INST_FRM_BITS];
    assign sqrt_dataa  = req_data[int'(grant)*DW +: DW];
    assign sqrt_reset  = ~reset_n;

    // The buffer drains into the requester named by the stored index.
    assign rsp_fire       = buf_valid_q && rsp_ready[buf_idx_q];
    assign sqrt_ready_out = ~buf_valid_q | rsp_fire;
    assign cap            = sqrt_valid_out && sqrt_ready_out;

    // Per-requester valid is one-hot decode of the buffered index.
    always_comb begin
        rsp_valid = '0;
        rsp_valid[buf_idx_q] = buf_valid_q;
    end

    assign rsp_tag        = buf_tag_q;
    assign rsp_result     = buf_res_q;
    assign rsp_has_fflags = buf_hf_q;
    assign rsp_fflags     = buf_ff_q;
    assign busy           = inflight_q != '0;

    // Next-state for pointer, credits and buffer occupancy.
    always_comb begin
        rr_d        = rr_q;
        inflight_d  = inflight_q;
        buf_valid_d = buf_valid_q;
        if (issue_fire)
            rr_d = (grant == IDW'(NUM_REQS - 1)) ? '0 : grant + 1'b1;
        if (issue_fire && !rsp_fire)
            inflight_d = inflight_q + 1'b1;
        else if (!issue_fire && rsp_fire)
            inflight_d = inflight_q - 1'b1;
        if (cap)
            buf_valid_d = 1'b1;
        else if (rsp_fire)
            buf_valid_d = 1'b0;
    end

    // Control state; reset drops every in-flight op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q        <= '0;
            inflight_q  <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            inflight_q  <= inflight_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // Payload capture; contents are don't-care while the buffer is empty.
    always_ff @(posedge clk) begin
        if (cap) begin
            buf_idx_q <= sqrt_tag_out[TAGW +: IDW];
            buf_tag_q <= sqrt_tag_out[TAGW-1:0];
            buf_res_q <= sqrt_result;
            buf_hf_q  <= sqrt_has_fflags;
            buf_ff_q  <= sqrt_fflags;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        inflight_q <= CNTW'(MAX_INFLIGHT));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp_fire && !issue_fire && inflight_q == '0));

endmodule

// File: tb/tb_vx_fpu_sqrt_sched.sv
// Bench for vx_fpu_sqrt_sched: queue-based fixed-latency pipe model, a
// scoreboard with its own round-robin/credit model, and directed scenarios.
module tb_vx_fpu_sqrt_sched;
    localparam int L   = 4;
    localparam int MAX = L + 2;

    logic clk = 1'b0;
    logic reset_n;
    logic [3:0]   req_valid, req_ready;
    logic [31:0]  req_tag;
    logic [11:0]  req_frm;
    logic [127:0] req_data;
    logic         sqrt_valid_in, sqrt_ready_in;
    logic [9:0]   sqrt_tag_in;
    logic [2:0]   sqrt_frm;
    logic [31:0]  sqrt_dataa;
    logic         sqrt_valid_out, sqrt_ready_out;
    logic [9:0]   sqrt_tag_out;
    logic [31:0]  sqrt_result;
    logic         sqrt_has_fflags;
    logic [4:0]   sqrt_fflags;
    logic         sqrt_reset;
    logic [3:0]   rsp_valid, rsp_ready;
    logic [7:0]   rsp_tag;
    logic [31:0]  rsp_result;
    logic         rsp_has_fflags;
    logic [4:0]   rsp_fflags;
    logic         busy;

    logic [7:0]  tg  [4];
    logic [31:0] dat [4];
    logic        pipe_rdy;

    int nchk = 0;
    int nerr = 0;

    vx_fpu_sqrt_sched #(.LATENCY_FSQRT(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_frm(req_frm), .req_data(req_data),
        .sqrt_valid_in(sqrt_valid_in), .sqrt_ready_in(sqrt_ready_in),
        .sqrt_tag_in(sqrt_tag_in), .sqrt_frm(sqrt_frm), .sqrt_dataa(sqrt_dataa),
        .sqrt_valid_out(sqrt_valid_out), .sqrt_ready_out(sqrt_ready_out),
        .sqrt_tag_out(sqrt_tag_out), .sqrt_result(sqrt_result),
        .sqrt_has_fflags(sqrt_has_fflags), .sqrt_fflags(sqrt_fflags),
        .sqrt_reset(sqrt_reset),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_has_fflags(rsp_has_fflags),
        .rsp_fflags(rsp_fflags), .busy(busy)
    );

    always #5 clk = ~clk;

    assign req_tag         = {tg[3], tg[2], tg[1], tg[0]};
    assign req_data        = {dat[3], dat[2], dat[1], dat[0]};
    assign req_frm         = {3'd3, 3'd2, 3'd1, 3'd0};
    assign sqrt_ready_in   = pipe_rdy;
    assign sqrt_has_fflags = 1'b1;

    // Square-root table for the operands used here: {result, NV,DZ,OF,UF,NX}.
    function automatic logic [36:0] sq(input logic [31:0] d);
        case (d)
            32'h40800000: sq = {32'h40000000, 5'b00000};
            32'hBF800000: sq = {32'h7FC00000, 5'b10000};
            32'h3F800000: sq = {32'h3F800000, 5'b00000};
            32'h41800000: sq = {32'h40800000, 5'b00000};
            32'h41100000: sq = {32'h40400000, 5'b00000};
            default:      sq = {d ^ 32'hA5A5A5A5, 5'b00001};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pipe model: accepts whenever pipe_rdy, emits an op L cycles after issue, holds head until taken.
    typedef struct {
        logic [9:0]  tag;
        logic [31:0] data;
        int          t;
    } pitem_t;
    pitem_t pq[$];
    int cyc;

    initial begin
        cyc = 0;
        sqrt_valid_out = 1'b0;
        sqrt_tag_out = '0;
        sqrt_result = '0;
        sqrt_fflags = '0;
        forever begin
            @(posedge clk or posedge sqrt_reset);
            if (sqrt_reset) begin
                pq.delete();
                sqrt_valid_out <= 1'b0;
            end else begin
                if (sqrt_valid_out && sqrt_ready_out) void'(pq.pop_front());
                if (sqrt_valid_in && sqrt_ready_in)
                    pq.push_back('{tag: sqrt_tag_in, data: sqrt_dataa, t: cyc});
                if (pq.size() > 0 && (cyc + 1 - pq[0].t) >= L) begin
                    sqrt_valid_out <= 1'b1;
                    sqrt_tag_out <= pq[0].tag;
                    {sqrt_result, sqrt_fflags} <= sq(pq[0].data);
                end else begin
                    sqrt_valid_out <= 1'b0;
                end
            end
            cyc = cyc + 1;
        end
    end

    // Scoreboard: round-robin pointer, credit count and in-order expected responses.
    typedef struct {
        int          idx;
        logic [7:0]  tag;
        logic [31:0] res;
        logic [4:0]  ff;
    } exp_t;
    exp_t eq[$];
    int   m_rr, m_cnt, m_g;
    bit   m_ok, m_hold;
    logic [3:0]  m_pv;
    logic [7:0]  m_ptag;
    logic [31:0] m_pres;

    initial begin
        m_rr = 0; m_cnt = 0; m_hold = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_rr = 0; m_cnt = 0; m_hold = 0;
                eq.delete();
                chk("rst_rsp_valid", rsp_valid, 4'b0);
                chk("rst_busy", busy, 0);
                chk("rst_req_ready", req_ready, 4'b0);
                chk("rst_sqrt_valid_in", sqrt_valid_in, 0);
            end else begin
                m_g = -1;
                for (int k = 0; k < 4; k++)
                    if (m_g < 0 && req_valid[(m_rr + k) % 4]) m_g = (m_rr + k) % 4;
                m_ok = m_cnt < MAX;
                chk("req_ready", req_ready,
                    (m_g >= 0 && m_ok && sqrt_ready_in) ? (4'b1 << m_g) : 4'b0);
                chk("sqrt_valid_in", sqrt_valid_in, (m_g >= 0) && m_ok);
                chk("busy", busy, m_cnt != 0);
                if (m_g >= 0) begin
                    chk("sqrt_tag_in", sqrt_tag_in, {m_g[1:0], req_tag[m_g*8 +: 8]});
                    chk("sqrt_frm", sqrt_frm, m_g[2:0]);
                    chk("sqrt_dataa", sqrt_dataa, req_data[m_g*32 +: 32]);
                end
                if (m_hold) begin
                    chk("stall_valid", rsp_valid, m_pv);
                    chk("stall_tag", rsp_tag, m_ptag);
                    chk("stall_result", rsp_result, m_pres);
                end
                if (rsp_valid != 0) begin
                    chk("rsp_onehot", $onehot(rsp_valid), 1);
                    if (eq.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, 4'b0);
                    end else begin
                        chk("rsp_idx", rsp_valid, 4'b1 << eq[0].idx);
                        chk("rsp_tag", rsp_tag, eq[0].tag);
                        chk("rsp_result", rsp_result, eq[0].res);
                        chk("rsp_fflags", rsp_fflags, eq[0].ff);
                        chk("rsp_has_fflags", rsp_has_fflags, 1);
                    end
                end
                m_hold = (rsp_valid != 0) && ((rsp_valid & rsp_ready) == 0);
                m_pv = rsp_valid; m_ptag = rsp_tag; m_pres = rsp_result;
                if ((rsp_valid & rsp_ready) != 0) begin
                    if (eq.size() > 0) void'(eq.pop_front());
                    m_cnt--;
                end
                if (m_g >= 0 && m_ok && sqrt_ready_in) begin
                    eq.push_back('{idx: m_g, tag: req_tag[m_g*8 +: 8],
                                   res: sq(req_data[m_g*32 +: 32]) >> 5,
                                   ff: sq(req_data[m_g*32 +: 32]) & 5'h1F});
                    m_rr = (m_g + 1) % 4;
                    m_cnt++;
                end
            end
        end
    end

    task automatic wait_idle(input string nm, output int nf);
        nf = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            if ((rsp_valid & rsp_ready) != 0) nf++;
            tick();
        end
        chk(nm, busy, 0);
    endtask

    task automatic do_reset();
        req_valid = 4'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n, nis, nrsp;
    logic [3:0] gl;

    initial begin
        reset_n = 1'b0;
        req_valid = 4'b0;
        rsp_ready = 4'b0;
        pipe_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin tg[i] = 8'(i); dat[i] = 32'h3F800000; end
        repeat (3) tick();
        chk("reset_state", {rsp_valid, req_ready, sqrt_valid_in, busy}, 10'b0);
        reset_n = 1'b1;
        tick();

        // single op on requester 0: sqrt(4.0)=2.0, L+1 cycles to response
        req_valid = 4'b0001; tg[0] = 8'h5A; dat[0] = 32'h40800000; rsp_ready = 4'hF;
        @(negedge clk);
        chk("t1_grant", req_ready, 4'b0001);
        n = 0;
        do begin
            tick();
            if (n == 0) req_valid = 4'b0;
            n++;
            @(negedge clk);
        end while (rsp_valid == 0 && n < 20);
        chk("t1_latency", n, L + 1);
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_tag", rsp_tag, 8'h5A);
        chk("t1_result", rsp_result, 32'h40000000);

        // issue and response in the same cycle; sqrt(-1) -> qNaN with NV
        tick();
        req_valid = 4'b0010; tg[1] = 8'h11; dat[1] = 32'hBF800000;
        @(negedge clk);
        chk("t4_issue_x", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0;
        repeat (L - 1) tick();
        tick();
        req_valid = 4'b0100; tg[2] = 8'h22; dat[2] = 32'h40800000;
        @(negedge clk);
        chk("t4_rsp_x", rsp_valid, 4'b0010);
        chk("t4_issue_y", req_ready, 4'b0100);
        chk("t4_tag", rsp_tag, 8'h11);
        chk("t4_result", rsp_result, 32'h7FC00000);
        chk("t4_nv", {rsp_has_fflags, rsp_fflags}, 6'b110000);
        tick();
        req_valid = 4'b0;
        @(negedge clk);
        chk("t4_busy_one_left", busy, 1);
        wait_idle("t4_idle", nrsp);

        // all requesters continuously: strict 0,1,2,3 rotation
        do_reset();
        dat[0] = 32'h3F800000; dat[1] = 32'h41800000; dat[2] = 32'h41100000; dat[3] = 32'h40800000;
        for (int i = 0; i < 4; i++) tg[i] = 8'(8'h10 * i);
        req_valid = 4'hF; rsp_ready = 4'hF;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            gl = req_ready;
            if (k < 8) chk("t2_rr_seq", req_ready, 4'b1 << (k % 4));
            tick();
            for (int i = 0; i < 4; i++) if (gl[i]) tg[i] = tg[i] + 8'd1;
        end
        req_valid = 4'b0;
        wait_idle("t2_idle", nrsp);

        // responses blocked for 20 cycles: credits cap issue at MAX
        do_reset();
        req_valid = 4'hF; rsp_ready = 4'b0; nis = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            nis += $countones(req_ready & req_valid);
            gl = req_ready;
            tick();
            for (int i = 0; i < 4; i++) if (gl[i]) tg[i] = tg[i] + 8'd1;
        end
        @(negedge clk);
        chk("t3_issued", nis, MAX);
        chk("t3_req_ready", req_ready, 4'b0);
        chk("t3_sqrt_valid_in", sqrt_valid_in, 0);
        chk("t3_busy", busy, 1);
        tick();
        req_valid = 4'b0; rsp_ready = 4'hF;
        wait_idle("t3_idle", nrsp);
        chk("t3_all_returned", nrsp, nis);

        // pointer wrap and priority after wrap; pipe back-pressure
        do_reset();
        req_valid = 4'b0100;
        @(negedge clk); chk("t5_grant2", req_ready, 4'b0100);
        tick(); req_valid = 4'b1000;
        @(negedge clk); chk("t5_grant3", req_ready, 4'b1000);
        tick(); req_valid = 4'b0101;
        @(negedge clk); chk("t5_wrap_grant0", req_ready, 4'b0001);
        tick();
        @(negedge clk); chk("t5_then_grant2", req_ready, 4'b0100);
        tick(); req_valid = 4'b0001; pipe_rdy = 1'b0;
        @(negedge clk);
        chk("t5_pipe_stall_ready", req_ready, 4'b0);
        chk("t5_pipe_stall_valid", sqrt_valid_in, 1);
        tick(); pipe_rdy = 1'b1; req_valid = 4'b0;
        wait_idle("t5_idle", nrsp);

        // async reset with 3 in flight and a full buffer
        do_reset();
        req_valid = 4'b0111; rsp_ready = 4'b0;
        repeat (3) tick();
        req_valid = 4'b0;
        n = 0;
        do begin @(negedge clk); n++; if (rsp_valid == 0) tick(); end
        while (rsp_valid == 0 && n < 20);
        chk("t6_buf_full", rsp_valid, 4'b0001);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_rsp_valid", rsp_valid, 4'b0);
        chk("t6_async_busy", busy, 0);
        repeat (2) tick();
        reset_n = 1'b1; rsp_ready = 4'hF;
        for (int k = 0; k < 2 * L; k++) begin
            @(negedge clk);
            chk("t6_no_stale", {rsp_valid, busy}, 5'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
